// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - nibble-serial add/subtract controller time-sharing one 4-bit ripple adder
//
// n_ripple_adder : N-bit ripple-carry adder (sum = a + b + c_in, carry on c_out).
// serial_add_ctrl: computes a+b or a-b one nibble per cycle, least significant first.
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request, sampled only while ready
//   op_sub   in   0 = a+b, 1 = a-b (captured with start)
//   a, b     in   W-bit operands (captured with start)
//   ready    out  idle, able to accept start
//   busy     out  nibbles being processed
//   done     out  one-cycle pulse, result/c_out/overflow valid
//   result   out  W-bit sum or difference, held until the next accept
//   c_out    out  final carry (subtraction: 1 = no borrow)
//   overflow out  two's-complement signed overflow

module n_ripple_adder #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   output logic [N-1:0] sum,
   output logic         c_out
);
   logic c;

   always_comb begin
      c   = c_in;
      sum = '0;
      for (int i = 0; i < N; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      c_out = c;
   end
endmodule

module serial_add_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   op_sub,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   output logic                   ready,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   c_out,
   output logic                   overflow
);
   localparam int W  = 4 * NIBBLES;
   localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  result_q, result_d;
   logic          sub_q, sub_d;
   logic          carry_q, carry_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [3:0]    nib_a, nib_b, nib_sum;
   logic          nib_cin, nib_cout;
   logic          last_nib;

   assign nib_a    = a_q[4*int'(cnt_q) +: 4];
   assign nib_b    = b_q[4*int'(cnt_q) +: 4];
   // First nibble takes its carry-in straight from the captured operation
   // (the +1 of the two's-complement negate); later nibbles chain the carry.
   assign nib_cin  = (cnt_q == '0) ? sub_q : carry_q;
   assign last_nib = (cnt_q == CW'(NIBBLES - 1));

   n_ripple_adder #(.N(4)) u_adder (
      .a     (nib_a),
      .b     (nib_b),
      .c_in  (nib_cin),
      .sum   (nib_sum),
      .c_out (nib_cout)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      sub_d    = sub_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d      = a;
               b_d      = op_sub ? ~b : b;
               sub_d    = op_sub;
               carry_d  = op_sub;
               cnt_d    = '0;
               result_d = '0;
               cout_d   = 1'b0;
               ovf_d    = 1'b0;
               state_d  = RUN;
            end
         end
         RUN: begin
            result_d[4*int'(cnt_q) +: 4] = nib_sum;
            carry_d = nib_cout;
            if (last_nib) begin
               // Counter stays on the top nibble; it is only rewound in DONE.
               cout_d  = nib_cout;
               // nib_sum[3] is the result sign bit being written this edge.
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (nib_sum[3] != a_q[W-1]);
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         sub_q    <= 1'b0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         sub_q    <= sub_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         cnt_q    <= cnt_d;
      end
   end

   assign ready    = (state_q == IDLE);
   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);
   assign result   = result_q;
   assign c_out    = cout_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;
   localparam int NIBBLES = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        op_sub;
   logic [15:0] a, b;
   logic        ready, busy, done;
   logic [15:0] result;
   logic        c_out, overflow;

   int tests = 0;
   int fails = 0;

   serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op_sub   (op_sub),
      .a        (a),
      .b        (b),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .c_out    (c_out),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        op;
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] r;
      logic        c;
      logic        v;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic on the operand values.
   task automatic model(input logic op, input logic [15:0] x, input logic [15:0] y,
                        output logic [15:0] r, output logic c, output logic v);
      int unsigned ux, uy;
      int          sx, sy, sr;
      ux = 32'(x);
      uy = 32'(y);
      sx = 32'($signed(x));
      sy = 32'($signed(y));
      if (!op) begin
         r  = 16'(ux + uy);
         c  = ((ux + uy) > 32'd65535);
         sr = sx + sy;
      end else begin
         r  = 16'(ux - uy);
         c  = (ux >= uy);
         sr = sx - sy;
      end
      v = (sr > 32767) || (sr < -32768);
   endtask

   task automatic run_op(input string tag, input logic op, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] er, input logic ec, input logic ev);
      int n;
      n = 0;
      while (!ready && n < 20) begin
         step();
         n++;
      end
      chk({tag, ":ready"}, 32'(ready), 32'd1);
      start  = 1'b1;
      op_sub = op;
      a      = x;
      b      = y;
      step();
      start  = 1'b0;
      op_sub = 1'($urandom);
      a      = 16'($urandom);
      b      = 16'($urandom);
      chk({tag, ":accept_busy"}, 32'(busy), 32'd1);
      chk({tag, ":accept_clear"}, 32'({result, c_out, overflow}), 32'd0);
      n = 1;
      while (!done && n < 20) begin
         step();
         n++;
      end
      chk({tag, ":latency"}, 32'(n - 1), 32'(NIBBLES));
      chk({tag, ":result"}, 32'(result), 32'(er));
      chk({tag, ":c_out"}, 32'(c_out), 32'(ec));
      chk({tag, ":overflow"}, 32'(overflow), 32'(ev));
      step();
      chk({tag, ":done_pulse"}, 32'({done, ready}), 32'b01);
      chk({tag, ":hold"}, 32'({result, c_out, overflow}), 32'({er, ec, ev}));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic        op;
      logic [15:0] x, y, r;
      logic        c, v;

      vecs[0] = '{"carry_chain", 1'b0, 16'h000F, 16'h0008, 16'h0017, 1'b0, 1'b0};
      vecs[1] = '{"carry_out",   1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{"signed_ovf",  1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{"sub_borrow",  1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
      vecs[4] = '{"sub_ovf",     1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
      vecs[5] = '{"add_1234",    1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0};

      rst_n  = 1'b0;
      start  = 1'b0;
      op_sub = 1'b0;
      a      = '0;
      b      = '0;
      #3;
      chk("reset_ready", 32'(ready), 32'd1);
      chk("reset_outs", 32'({busy, done, result, c_out, overflow}), 32'd0);
      step();
      step();
      #4 rst_n = 1'b1;
      step();

      for (int i = 0; i < 6; i++)
         run_op(vecs[i].name, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].c, vecs[i].v);

      // start pulses while RUN and while DONE must be ignored
      n = 0;
      while (!ready && n < 20) begin step(); n++; end
      start = 1'b1; op_sub = 1'b0; a = 16'h000F; b = 16'h0008;
      step();
      a = 16'hFFFF; b = 16'hFFFF; op_sub = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (!done && n < 20) begin step(); n++; end
      chk("ign:run_result", 32'(result), 32'h0017);
      start = 1'b1; a = 16'h1111; b = 16'h2222; op_sub = 1'b0;
      step();
      start = 1'b0;
      chk("ign:done_start", 32'({ready, busy, done}), 32'b100);
      chk("ign:held", 32'(result), 32'h0017);
      step();
      chk("ign:still_idle", 32'({busy, done}), 32'd0);

      // back-to-back issue: run_op drives start in the cycle right after done
      run_op("b2b_first", 1'b0, 16'h0101, 16'h0202, 16'h0303, 1'b0, 1'b0);
      run_op("b2b_second", 1'b1, 16'h0303, 16'h0101, 16'h0202, 1'b1, 1'b0);

      // reset mid-RUN during nibble 2
      start = 1'b1; op_sub = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
      step();
      start = 1'b0;
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid:ready", 32'(ready), 32'd1);
      chk("rst_mid:outs", 32'({busy, done, result, c_out, overflow}), 32'd0);
      step();
      #4 rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done) n++;
      end
      chk("rst_mid:no_done", 32'(n), 32'd0);
      run_op("rst_mid:after", 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0);

      // randomized operations against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         op = 1'($urandom);
         case ($urandom_range(0, 3))
            0: x = 16'h8000;
            1: x = 16'h7FFF;
            default: x = 16'($urandom);
         endcase
         y = (i % 5 == 0) ? 16'hFFFF : 16'($urandom);
         model(op, x, y, r, c, v);
         run_op($sformatf("rand%0d", i), op, x, y, r, c, v);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, gives the number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  rising-edge clock; the block has exactly one clock.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request; sampled only while ready=1.
REQ-005 op_sub  input  1  0 = a+b, 1 = a-b; captured with start.
REQ-006 a  input  W  operand A; captured with start.
REQ-007 b  input  W  operand B; captured with start.
REQ-008 ready  output  1  high only in IDLE.
REQ-009 busy  output  1  high in RUN.
REQ-010 done  output  1  one-cycle pulse; result, c_out and overflow are valid while it is high.
REQ-011 result  output  W  sum or difference.
REQ-012 c_out  output  1  final carry; for subtraction, 1 = no borrow.
REQ-013 overflow  output  1  two's-complement signed overflow of the operation.

Function
REQ-014 The block SHALL contain exactly one 4-bit n_ripple_adder instance (ports sum, c_out, a, b, c_in) and SHALL time-share it over all nibbles; no other adder is permitted.
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after nibble NIBBLES-1 is processed.
- DONE -> IDLE unconditionally.
REQ-016 On accept, the block SHALL register:
- a;
- b, inverted when op_sub=1;
- op_sub;
- carry register = op_sub;
- nibble counter = 0.
REQ-017 In RUN, each cycle SHALL process one nibble, least significant first.
- Adder inputs: nibble k of the captured A, nibble k of the captured B, and the carry register.
- At the clock edge: write the adder sum into result nibble k, load the adder c_out into the carry register, and increment k.
REQ-018 Latency: start is accepted at edge T0 and nibbles are written at edges T1..T_NIBBLES. done SHALL be high in the cycle following edge T_NIBBLES, i.e. for NIBBLES=4 it goes high 4 cycles after the accept edge.
REQ-019 In DONE, c_out SHALL equal the carry register.
REQ-020 In DONE, overflow SHALL be 1 exactly when the captured A[W-1] equals the captured B[W-1] and result[W-1] differs from them.
REQ-021 result, c_out and overflow SHALL hold their values from DONE until the next accepted start. On acceptance, result, c_out and overflow SHALL clear to 0.
REQ-022 start while busy=1 or done=1 SHALL be ignored: no capture, and no effect on the operation in progress.
REQ-023 start in the cycle immediately after done (state IDLE) SHALL be accepted; minimum issue interval is NIBBLES+2 cycles.
REQ-024 Changes on a, b or op_sub after acceptance SHALL NOT affect the operation.
REQ-025 The nibble counter SHALL wrap from NIBBLES-1 only via DONE; it SHALL never index beyond nibble NIBBLES-1.
REQ-026 Arithmetic is modulo 2^W; any carry beyond bit W-1 appears only on c_out.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock edge:
- force state IDLE;
- set ready=1;
- set busy=0, done=0, result=0, c_out=0, overflow=0;
- clear the counter, the carry register and the operand registers.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse. The first start after rst_n deasserts SHALL execute normally.

Verification
REQ-029 Reset: assert rst_n=0 mid-cycle -> all outputs 0 and ready=1 before the next edge.
REQ-030 Carry chain: NIBBLES=4, op_sub=0, a=16'h000F, b=16'h0008 -> done 4 cycles after accept, result=16'h0017, c_out=0, overflow=0.
REQ-031 Carry out: op_sub=0, a=16'hFFFF, b=16'h0001 -> result=16'h0000, c_out=1, overflow=0.
REQ-032 Signed overflow: op_sub=0, a=16'h7FFF, b=16'h0001 -> result=16'h8000, c_out=0, overflow=1.
REQ-033 Subtraction:
- op_sub=1, a=16'h0005, b=16'h0007 -> result=16'hFFFE, c_out=0, overflow=0;
- op_sub=1, a=16'h8000, b=16'h0001 -> result=16'h7FFF, overflow=1.
REQ-034 Protocol:
- start pulses with new operands during RUN and during DONE -> ignored, and the first result is unchanged;
- start in the cycle after done -> accepted;
- rst_n pulsed low during nibble 2 -> no done pulse, outputs 0, and the following a=16'h1234, b=16'h1111 add gives result=16'h2345.
